// File: rtl/conv_1d_seq_ctrl_if.sv
// Column stream bundle of the 1-D conv sequencer: image columns in, result columns out.
// The sequencer binds to the slave modport; the stream source/sink binds to master.
interface conv_1d_seq_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_D      = 8,
  parameter int RESULT_D   = 8
);
  logic                           in_valid;
  logic                           in_ready;
  logic [DATA_WIDTH*IMG_D-1:0]    in_data;
  logic [7:0]                     in_tag;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_WIDTH*RESULT_D-1:0] out_data;
  logic                           out_last;
  logic [7:0]                     out_tag;

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_last, out_tag
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_tag
  );
endinterface

// File: rtl/conv_1d_seq_ctrl.sv
// Sequencer for a fully parallel 1-D conv datapath: loads an image column by column,
// holds it on dp_lines_in for PIPE_LAT cycles, captures the result and streams it out.
module conv_1d_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 32,
  parameter int IMG_D      = 8,
  parameter int FILTER_L   = 3,
  parameter int RESULT_D   = 8,
  parameter int STRIDE_W   = 1,
  parameter int PIPE_LAT   = 5,
  localparam int RESULT_W  = (IMG_W - FILTER_L) / STRIDE_W + 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  conv_1d_seq_ctrl_if.slave                      bus,
  output logic [DATA_WIDTH*IMG_D*IMG_W-1:0]      dp_lines_in,
  input  logic [DATA_WIDTH*RESULT_D*RESULT_W-1:0] dp_lines_out,
  output logic                                   busy
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int LW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int OW = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
  localparam int RB = DATA_WIDTH * RESULT_D * RESULT_W;

  typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_WAIT = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CW-1:0]           col_cnt;
  logic [LW-1:0]           lat_cnt;
  logic [OW-1:0]           out_cnt;
  logic [DATA_WIDTH-1:0]   lines [IMG_D][IMG_W];
  logic [RB-1:0]           result;
  logic [7:0]              tag;
  logic                    accept;
  logic                    col_last;
  logic                    lat_done;
  logic                    out_fire;
  logic                    out_end;
  logic [DATA_WIDTH*RESULT_D-1:0] out_col;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake qualifiers
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    out_fire  = 1'b0;
    col_last  = (col_cnt == CW'(IMG_W - 1));
    lat_done  = (lat_cnt == LW'(PIPE_LAT - 1));
    out_end   = (out_cnt == OW'(RESULT_W - 1));
    case (state)
      ST_LOAD: begin
        accept = bus.in_valid;
        if (bus.in_valid && col_last) begin
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      ST_WAIT: begin
        if (lat_done) begin
          state_nxt = ST_DRAIN;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        out_fire = bus.out_ready;
        if (bus.out_ready && out_end) begin
          state_nxt = ST_LOAD;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Line buffer, counters, tag and result capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_cnt <= '0;
      lat_cnt <= '0;
      out_cnt <= '0;
      tag     <= 8'h00;
      result  <= '0;
      for (int k = 0; k < IMG_D; k++) begin
        for (int w = 0; w < IMG_W; w++) begin
          lines[k][w] <= '0;
        end
      end
    end else begin
      if (accept) begin
        for (int k = 0; k < IMG_D; k++) begin
          lines[k][col_cnt] <= bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
        if (col_cnt == '0) begin
          tag <= bus.in_tag;
        end
        if (col_last) begin
          col_cnt <= '0;
          lat_cnt <= '0;
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
      if (state == ST_WAIT) begin
        if (lat_done) begin
          result  <= dp_lines_out;
          out_cnt <= '0;
        end else begin
          lat_cnt <= lat_cnt + LW'(1);
        end
      end
      // The final column leaves out_cnt at its terminal value; it is reloaded on capture.
      if (out_fire && !out_end) begin
        out_cnt <= out_cnt + OW'(1);
      end
    end
  end

  // Line buffer packing and result column select
  always_comb begin
    dp_lines_in = '0;
    out_col     = '0;
    for (int k = 0; k < IMG_D; k++) begin
      for (int w = 0; w < IMG_W; w++) begin
        dp_lines_in[(k*IMG_W + w)*DATA_WIDTH +: DATA_WIDTH] = lines[k][w];
      end
    end
    for (int i = 0; i < RESULT_D; i++) begin
      out_col[i*DATA_WIDTH +: DATA_WIDTH] =
        result[(i*RESULT_W + int'(out_cnt))*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stream outputs decoded from registered state; quiet outside DRAIN
  always_comb begin
    bus.in_ready  = (state == ST_LOAD);
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.out_tag   = 8'h00;
    busy          = (state != ST_LOAD) || (col_cnt != '0);
    if (state == ST_DRAIN) begin
      bus.out_valid = 1'b1;
      bus.out_data  = out_col;
      bus.out_last  = out_end;
      bus.out_tag   = tag;
    end else begin
      bus.out_valid = 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_1d_seq_ctrl.sv
// Self-checking bench for conv_1d_seq_ctrl: two instances (PIPE_LAT=3 and PIPE_LAT=1)
// fed by random images, each driving a behavioural conv datapath and checked against golden columns.
module tb_conv_1d_seq_ctrl;
  localparam int DW = 8, IW = 8, ID = 2, FL = 3, RD = 2, SW = 1;
  localparam int RW = (IW - FL) / SW + 1;
  localparam int LB = DW * ID * IW, RB = DW * RD * RW, IB = DW * ID, OB = DW * RD;

  typedef struct packed {
    logic [OB-1:0] data;
    logic          last;
    logic [7:0]    tag;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sel, in_valid, out_ready;
  logic [IB-1:0] in_data;
  logic [7:0]    in_tag;
  logic [LB-1:0] dpin_a, dpin_b, o_dp_in, snap;
  logic [RB-1:0] dpout_a, dpout_b, pa0, pa1;
  logic          busy_a, busy_b;
  logic          o_in_ready, o_out_valid, o_out_last, o_busy;
  logic [OB-1:0] o_out_data;
  logic [7:0]    o_out_tag;

  int total = 0, passed = 0, failed = 0, cyc = 0, last_e0 = 0, loads_done = 0;
  int img [IW][ID];
  beat_t exp_q [$];

  conv_1d_seq_ctrl_if #(.DATA_WIDTH(DW), .IMG_D(ID), .RESULT_D(RD)) ifa ();
  conv_1d_seq_ctrl_if #(.DATA_WIDTH(DW), .IMG_D(ID), .RESULT_D(RD)) ifb ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
  assign ifa.in_data = in_data;    assign ifb.in_data = in_data;
  assign ifa.in_tag = in_tag;      assign ifb.in_tag = in_tag;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

  conv_1d_seq_ctrl #(.DATA_WIDTH(DW), .IMG_W(IW), .IMG_D(ID), .FILTER_L(FL), .RESULT_D(RD),
                     .STRIDE_W(SW), .PIPE_LAT(3)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa), .dp_lines_in(dpin_a), .dp_lines_out(dpout_a), .busy(busy_a));
  conv_1d_seq_ctrl #(.DATA_WIDTH(DW), .IMG_W(IW), .IMG_D(ID), .FILTER_L(FL), .RESULT_D(RD),
                     .STRIDE_W(SW), .PIPE_LAT(1)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb), .dp_lines_in(dpin_b), .dp_lines_out(dpout_b), .busy(busy_b));

  assign o_in_ready  = sel ? ifb.in_ready  : ifa.in_ready;
  assign o_out_valid = sel ? ifb.out_valid : ifa.out_valid;
  assign o_out_last  = sel ? ifb.out_last  : ifa.out_last;
  assign o_out_data  = sel ? ifb.out_data  : ifa.out_data;
  assign o_out_tag   = sel ? ifb.out_tag   : ifa.out_tag;
  assign o_dp_in     = sel ? dpin_b : dpin_a;
  assign o_busy      = sel ? busy_b : busy_a;

  function automatic logic [7:0] wt(input int i, input int k, input int f);
    return 8'(i * 7 + k * 3 + f * 5 + 1);
  endfunction

  // Datapath model: reads the flat lines_in layout, writes the flat lines_out layout
  function automatic logic [RB-1:0] dp_conv(input logic [LB-1:0] li);
    logic [RB-1:0] r;
    int acc;
    r = '0;
    for (int i = 0; i < RD; i++) begin
      for (int j = 0; j < RW; j++) begin
        acc = 0;
        for (int k = 0; k < ID; k++)
          for (int f = 0; f < FL; f++)
            acc += int'(li[(k*IW + j*SW + f)*DW +: DW]) * int'(wt(i, k, f));
        r[(i*RW + j)*DW +: DW] = 8'(acc);
      end
    end
    return r;
  endfunction

  // PIPE_LAT=3 datapath: result valid before the 3rd edge after lines_in settles
  always @(posedge clk) begin
    pa0 <= dp_conv(dpin_a);
    pa1 <= pa0;
    cyc <= cyc + 1;
  end
  assign dpout_a = pa1;
  assign dpout_b = dp_conv(dpin_b);

  task automatic chk(input string name, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Output monitor: scoreboard, stall hold, freeze of lines_in, latency and release checks
  initial begin : monitor
    beat_t b;
    logic prev_stall, prev_valid, prev_last, frozen, last_done;
    logic [OB-1:0] prev_data;
    int seen_loads;
    prev_stall = 1'b0; prev_valid = 1'b0; prev_last = 1'b0; frozen = 1'b0; last_done = 1'b0;
    prev_data = '0; seen_loads = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        prev_stall = 1'b0; prev_valid = 1'b0; frozen = 1'b0; last_done = 1'b0;
        seen_loads = loads_done;
      end else begin
        if (seen_loads != loads_done) begin
          frozen = 1'b1;
          seen_loads = loads_done;
        end
        if (last_done) begin
          chk("in_ready_after_last", LB'(o_in_ready), LB'(1));
          chk("valid_drop_after_last", LB'(o_out_valid), LB'(0));
          last_done = 1'b0;
        end
        if (o_out_valid && !prev_valid) chk("valid_rise_latency", LB'(cyc - last_e0), LB'(sel ? 1 : 3));
        if (prev_stall) begin
          chk("stall_valid", LB'(o_out_valid), LB'(1));
          chk("stall_data", LB'(o_out_data), LB'(prev_data));
          chk("stall_last", LB'(o_out_last), LB'(prev_last));
        end
        if (frozen) begin
          chk("lines_in_frozen", o_dp_in, snap);
          chk("in_ready_low_busy", LB'(o_in_ready), LB'(0));
          chk("busy_high", LB'(o_busy), LB'(1));
        end
        if (o_out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", LB'(1), LB'(0));
          end else begin
            b = exp_q.pop_front();
            chk("out_data", LB'(o_out_data), LB'(b.data));
            chk("out_last", LB'(o_out_last), LB'(b.last));
            chk("out_tag", LB'(o_out_tag), LB'(b.tag));
            if (b.last) begin
              frozen = 1'b0;
              last_done = 1'b1;
            end
          end
        end
        prev_stall = o_out_valid && !out_ready;
        prev_valid = o_out_valid;
        prev_data  = o_out_data;
        prev_last  = o_out_last;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", LB'(o_out_valid), LB'(0));
    chk("rst_out_last", LB'(o_out_last), LB'(0));
    chk("rst_out_data", LB'(o_out_data), LB'(0));
    chk("rst_out_tag", LB'(o_out_tag), LB'(0));
    chk("rst_lines_in", o_dp_in, LB'(0));
    chk("rst_busy", LB'(o_busy), LB'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", LB'(o_in_ready), LB'(1));
  endtask

  // Drive ncols columns of a fresh random image; golden result queued only for whole images
  task automatic load_image(input logic [7:0] tag, input int ncols, input int gap_pct, input bit hold);
    logic [OB-1:0] col;
    logic [IB-1:0] d;
    int acc, n;
    bit ok;
    for (int c = 0; c < IW; c++)
      for (int k = 0; k < ID; k++) img[c][k] = int'($urandom_range(0, 255));
    if (ncols == IW) begin
      for (int j = 0; j < RW; j++) begin
        col = '0;
        for (int i = 0; i < RD; i++) begin
          acc = 0;
          for (int f = 0; f < FL; f++)
            for (int k = 0; k < ID; k++) acc += img[j*SW + f][k] * int'(wt(i, k, f));
          col[i*DW +: DW] = 8'(acc);
        end
        exp_q.push_back('{data: col, last: (j == RW - 1), tag: tag});
      end
    end
    in_tag = tag;
    for (int c = 0; c < ncols; c++) begin
      while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < ID; k++) d[k*DW +: DW] = 8'(img[c][k]);
      in_valid = 1'b1;
      in_data = d;
      ok = 1'b0;
      n = 0;
      while (!ok && n < 200) begin
        @(negedge clk);
        ok = o_in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!ok) chk("accept_timeout", LB'(0), LB'(1));
      if (c == 0) chk("busy_after_first_beat", LB'(o_busy), LB'(1));
    end
    if (ncols == IW) begin
      last_e0 = cyc;
      snap = o_dp_in;
      loads_done++;
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // mode 0: out_ready high, 1: toggle every cycle, 2: random
  task automatic wait_idle(input int mode);
    int n;
    n = 0;
    while (n < 300 && (exp_q.size() != 0 || o_out_valid)) begin
      @(posedge clk);
      #1;
      out_ready = (mode == 1) ? ~out_ready : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    if (exp_q.size() != 0 || o_out_valid) chk("drain_timeout", LB'(0), LB'(1));
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    sel = 1'b0; rst = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = 8'h00; out_ready = 1'b1;
    do_reset();
    load_image(8'hA5, IW, 0, 1'b0);
    wait_idle(0);
    load_image(8'h5A, IW, 50, 1'b0);
    wait_idle(0);
    load_image(8'h77, IW, 0, 1'b0);
    wait_idle(1);
    load_image(8'h99, 4, 0, 1'b0);
    do_reset();
    load_image(8'h3C, IW, 0, 1'b0);
    wait_idle(0);
    load_image(8'h11, IW, 0, 1'b1);
    load_image(8'h22, IW, 0, 1'b0);
    wait_idle(0);
    for (int r = 0; r < 4; r++) begin
      load_image(8'($urandom_range(0, 255)), IW, 30, 1'b0);
      wait_idle(2);
    end
    sel = 1'b1;
    do_reset();
    load_image(8'h6E, IW, 0, 1'b0);
    wait_idle(0);
    load_image(8'hC3, IW, 40, 1'b0);
    wait_idle(1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
